// File: rtl/wb_pkg.sv
// Shared constants and entry layout for the write-back queue.
package wb_pkg;

  // Opcode prefixes: five-bit classes plus the full six-bit halt opcode
  localparam logic [4:0] OP_LOAD = 5'b11000;
  localparam logic [4:0] OP_RR   = 5'b00000;
  localparam logic [4:0] OP_RI   = 5'b00101;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Destination field positions inside the instruction word
  localparam int RD_LSB = 11;
  localparam int RT_LSB = 16;

  // Default field widths used by the reference entry layout
  localparam int DW_DEF = 32;
  localparam int IW_DEF = 32;
  localparam int AW_DEF = 5;

  // Reference layout of one queued entry at the default widths; the queue
  // declares a parameter-sized twin with the same field order.
  typedef struct packed {
    logic              we;
    logic              is_halt;
    logic [AW_DEF-1:0] waddr;
    logic [DW_DEF-1:0] wdata;
    logic [IW_DEF-1:0] ir;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH-entry synchronous FIFO with first-word-fall-through head.
// Pointers carry one extra bit so full and empty can be told apart.
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wptr_reg;
  logic [PW:0]  rptr_reg;
  logic [W-1:0] mem_reg [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (wptr_reg == rptr_reg);
  assign full    = (wptr_reg[PW] != rptr_reg[PW]) &&
                   (wptr_reg[PW-1:0] == rptr_reg[PW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // The head must be visible the cycle after it is written, so the read
  // is taken straight from the storage array.
  assign head_data = mem_reg[rptr_reg[PW-1:0]];

  // Pointer update; reset discards every stored entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + 1'b1;
      if (pop_ok)  rptr_reg <= rptr_reg + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wptr_reg[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back stage: decodes completed instructions, queues them and drives
// the register-file write port; tracks retirements and a sticky halt.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int IW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  parameter int CW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_ir,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_lmd,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic          rf_ready,
  output logic          wb_valid,
  output logic [IW-1:0] wb_ir,
  output logic          halted,
  output logic [CW-1:0] retired
);

  typedef struct packed {
    logic          we;
    logic          is_halt;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [IW-1:0] ir;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t        in_entry;
  entry_t        head;
  logic [4:0]    op5;
  logic [5:0]    op6;
  logic          fifo_full;
  logic          fifo_empty;
  logic          enq;
  logic          deq;
  logic          halt_seen_reg;
  logic          halted_reg;
  logic [CW-1:0] retired_reg;

  assign op5 = in_ir[IW-1 -: 5];
  assign op6 = in_ir[IW-1 -: 6];

  // Decode result source and destination; r0 is never written
  always_comb begin
    in_entry.we      = 1'b0;
    in_entry.is_halt = 1'b0;
    in_entry.waddr   = '0;
    in_entry.wdata   = in_alu;
    in_entry.ir      = in_ir;
    case (op5)
      OP_LOAD: begin
        in_entry.wdata = in_lmd;
        in_entry.waddr = in_ir[RT_LSB +: AW];
        in_entry.we    = 1'b1;
      end
      OP_RR: begin
        in_entry.waddr = in_ir[RD_LSB +: AW];
        in_entry.we    = 1'b1;
      end
      OP_RI: begin
        in_entry.waddr = in_ir[RT_LSB +: AW];
        in_entry.we    = 1'b1;
      end
      default: ;
    endcase
    if (op6 == OP_HALT) in_entry.is_halt = 1'b1;
    if (in_entry.waddr == '0) in_entry.we = 1'b0;
  end

  // Handshakes; all outputs are held quiet while reset is asserted
  assign in_ready = rst_n && !fifo_full && !halt_seen_reg;
  assign enq      = in_valid && in_ready;
  assign wb_valid = rst_n && !fifo_empty;
  assign deq      = wb_valid && (rf_ready || !head.we);
  assign rf_we    = wb_valid && head.we;
  assign rf_waddr = wb_valid ? head.waddr : '0;
  assign rf_wdata = wb_valid ? head.wdata : '0;
  assign wb_ir    = wb_valid ? head.ir    : '0;
  assign halted   = halted_reg;
  assign retired  = retired_reg;

  wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (enq),
    .push_data (in_entry),
    .pop       (deq),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Halt tracking and the wrapping retirement counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt_seen_reg <= 1'b0;
      halted_reg    <= 1'b0;
      retired_reg   <= '0;
    end else begin
      if (enq && in_entry.is_halt) halt_seen_reg <= 1'b1;
      if (deq && head.is_halt)     halted_reg    <= 1'b1;
      if (deq)                     retired_reg   <= retired_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with DEPTH=2 and a 4-bit retire counter.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ir;
  logic [31:0] in_alu;
  logic [31:0] in_lmd;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ready;
  logic        wb_valid;
  logic [31:0] wb_ir;
  logic        halted;
  logic [3:0]  retired;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  wb_queue #(
    .DW(32), .IW(32), .AW(5), .DEPTH(2), .CW(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ir    (in_ir),
    .in_alu   (in_alu),
    .in_lmd   (in_lmd),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rf_ready (rf_ready),
    .wb_valid (wb_valid),
    .wb_ir    (wb_ir),
    .halted   (halted),
    .retired  (retired)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle push attempt starting just after a rising edge
  task automatic push_one(input logic [31:0] ir, input logic [31:0] alu,
                          input logic [31:0] lmd, output logic acc);
    in_valid = 1'b1;
    in_ir    = ir;
    in_alu   = alu;
    in_lmd   = lmd;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("push ir=0x%08h alu=0x%08h lmd=0x%08h accepted=%0d", ir, alu, lmd, acc);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_rf_we",    rf_we,    0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_retired",  retired,  0);
    check("rst_halted",   halted,   0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    $display("reset applied");
  endtask

  logic acc;
  int   n_acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ir = '0; in_alu = '0; in_lmd = '0; rf_ready = 1'b0;

    // Load vs ALU vs reg-imm selection
    do_reset();
    rf_ready = 1'b1;
    push_one(32'hC0A20000, 32'h12345678, 32'h87654321, acc);
    check("ld_acc", acc, 1);
    @(negedge clk);
    check("ld_we",    rf_we,    1);
    check("ld_addr",  rf_waddr, 2);
    check("ld_data",  rf_wdata, 32'h87654321);
    check("ld_ir",    wb_ir,    32'hC0A20000);
    step();
    push_one(32'h00221800, 32'hAAAABBBB, 32'h0, acc);
    @(negedge clk);
    check("rr_addr", rf_waddr, 3);
    check("rr_data", rf_wdata, 32'hAAAABBBB);
    step();
    push_one(32'h28070000, 32'h0000BEEF, 32'h00005555, acc);
    @(negedge clk);
    check("ri_addr", rf_waddr, 7);
    check("ri_data", rf_wdata, 32'h0000BEEF);
    step();
    @(negedge clk);
    check("sel_retired", retired, 3);
    check("sel_empty",   wb_valid, 0);
    check("sel_wdata0",  rf_wdata, 0);
    step();

    // Back-pressure and full
    do_reset();
    rf_ready = 1'b0;
    push_one(32'h00002000, 32'h11, 32'h0, acc);
    check("bp_acc_a", acc, 1);
    push_one(32'h00002800, 32'h22, 32'h0, acc);
    check("bp_acc_b", acc, 1);
    push_one(32'h00003000, 32'h33, 32'h0, acc);
    check("bp_full_refuse", acc, 0);
    rf_ready = 1'b1;
    @(negedge clk);
    check("bp_a_addr", rf_waddr, 4);
    check("bp_a_data", rf_wdata, 32'h11);
    step();
    @(negedge clk);
    check("bp_b_addr", rf_waddr, 5);
    check("bp_b_data", rf_wdata, 32'h22);
    step();
    @(negedge clk);
    check("bp_retired", retired, 2);
    step();
    push_one(32'h00003000, 32'h33, 32'h0, acc);
    check("bp_acc_c", acc, 1);
    @(negedge clk);
    check("bp_c_addr", rf_waddr, 6);
    step();

    // r0 destination and non-writing opcode retire without a grant
    do_reset();
    rf_ready = 1'b0;
    push_one(32'h00000000, 32'h99, 32'h0, acc);
    check("r0_acc", acc, 1);
    in_valid = 1'b1;
    in_ir    = 32'hC8000000;
    @(negedge clk);
    check("r0_valid", wb_valid, 1);
    check("r0_we",    rf_we,    0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("push ir=0x%08h alu=0x%08h lmd=0x%08h accepted=1", 32'hC8000000, in_alu, in_lmd);
    @(negedge clk);
    check("nw_ir", wb_ir, 32'hC8000000);
    check("nw_we", rf_we, 0);
    step();
    @(negedge clk);
    check("nw_retired", retired, 2);
    check("nw_empty",   wb_valid, 0);
    step();

    // Halt blocks input and sets halted on dequeue
    do_reset();
    rf_ready = 1'b1;
    push_one(32'h00000800, 32'h1, 32'h0, acc);
    push_one(32'hFC000000, 32'h0, 32'h0, acc);
    check("h_acc", acc, 1);
    @(negedge clk);
    check("h_not_yet",  halted,   0);
    check("h_head_ir",  wb_ir,    32'hFC000000);
    check("h_blocked",  in_ready, 0);
    step();
    push_one(32'h00001000, 32'h2, 32'h0, acc);
    check("h_refuse", acc, 0);
    @(negedge clk);
    check("h_halted",  halted,  1);
    check("h_retired", retired, 2);
    step();

    // Counter wrap at CW=4, then reset with entries queued
    do_reset();
    rf_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 17; i++) begin
      push_one(32'h00000800, i, 32'h0, acc);
      if (acc) n_acc++;
    end
    check("wr_accepts", n_acc, 17);
    step();
    @(negedge clk);
    check("wr_retired", retired, 1);
    step();
    rf_ready = 1'b0;
    push_one(32'h00000800, 32'hA, 32'h0, acc);
    push_one(32'h00001000, 32'hB, 32'h0, acc);
    @(negedge clk);
    check("mr_valid_pre", wb_valid, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_we_during", rf_we,    0);
    check("mr_rdy_during", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("mid-operation reset applied");
    @(negedge clk);
    check("mr_empty",   wb_valid, 0);
    check("mr_retired", retired,  0);
    check("mr_we",      rf_we,    0);
    check("mr_addr",    rf_waddr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
Registered, parametrised write-back stage for the MIPS32 pipeline. It accepts completed instructions from MEM with a valid/ready handshake and selects the result: LMD for loads, ALU otherwise. It decodes the destination register, buffers entries in a DEPTH-deep queue, and drives the register-file write port under an rf_ready grant. It also tracks retired instructions and a sticky halt.

Parameters:
DW, 32, data width of ALU/LMD/write data
IW, 32, instruction width (opcode always IR[IW-1:IW-6])
AW, 5, register address width
DEPTH, 2, queue entries (power of 2, >=2)
CW, 32, retired-instruction counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  MEM-stage entry valid
in_ready  out  1  stage can accept entry
in_ir  in  IW  instruction (IR_mx)
in_alu  in  DW  ALU result
in_lmd  in  DW  load memory data
rf_we  out  1  register-file write request
rf_waddr  out  AW  write address
rf_wdata  out  DW  write data
rf_ready  in  1  write port granted this cycle
wb_valid  out  1  queue head valid
wb_ir  out  IW  head instruction (IR_wb)
halted  out  1  sticky: halt instruction retired
retired  out  CW  retired-instruction count

Behaviour:
- Reset (rst_n=0 at clk edge): queue empty, read/write pointers 0, halt_seen=0, halted=0, retired=0. Outputs: in_ready=0 during reset, rf_we=0, wb_valid=0, rf_waddr=0, rf_wdata=0, wb_ir=0. Reset mid-operation flushes all entries; no write occurs that cycle.
- Decode at enqueue, with op5=IR[IW-1:IW-5]:
  - 11000 (load): data=LMD, dest=IR[20:16], we=1
  - 00000 (reg-reg): data=ALU, dest=IR[15:11], we=1
  - 00101 (reg-imm): data=ALU, dest=IR[20:16], we=1
  - opcode 111111: halt, we=0
  - anything else: data=ALU, we=0
  - dest==0 forces we=0 (r0 never written).
- Enqueue: in_valid && in_ready. in_ready = rst_n && !full && !halt_seen. When full, no enqueue even if a dequeue happens the same cycle.
- Latency: an entry accepted at edge N is at the head and visible on the outputs after edge N (earliest write cycle N+1). Back-to-back throughput is 1/cycle with rf_ready=1.
- Head outputs: wb_valid=!empty; rf_we=wb_valid && head.we; rf_waddr/rf_wdata/wb_ir come from the head. They are 0 when empty.
- Dequeue: wb_valid && (rf_ready || !head.we). Non-writing entries retire without waiting for the grant. Each dequeue increments retired, which wraps modulo 2^CW.
- Simultaneous enqueue and dequeue (not full): count unchanged, order preserved (FIFO).
- Halt: halt_seen sets on halt enqueue, which blocks further input. halted sets on halt dequeue and holds until reset. Entries ahead of the halt still drain.
- Pointers wrap at DEPTH; full/empty tracked with an extra pointer bit.

Decomposition:
- Package wb_pkg:
  - opcode prefix constants OP_LOAD=5'b11000, OP_RR=5'b00000, OP_RI=5'b00101, OP_HALT=6'b111111
  - field positions RD_LSB=11, RT_LSB=16
  - entry struct {we, is_halt, waddr, wdata, ir}
- Sub-module wb_fifo: generic DEPTH-entry synchronous FIFO (push/pop/full/empty, sync active-low reset). Decode and halt/counter logic live in wb_queue.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, rf_we=0, retired=0, halted=0.
- Load vs ALU: push IR=0xC0A20000 (op5=11000, rt=2), ALU=0x12345678, LMD=0x87654321 with rf_ready=1 -> next cycle rf_we=1, rf_waddr=2, rf_wdata=0x87654321. Push IR=0x00221800 (rd=3), ALU=0xAAAABBBB -> rf_waddr=3, rf_wdata=0xAAAABBBB.
- Back-pressure/full: rf_ready=0, push 3 writing entries with DEPTH=2 -> in_ready=0 after 2 accepted. Raise rf_ready -> writes drain in order, retired=2, then the third entry is accepted.
- r0 and non-writing ops: push reg-reg with rd=0 and opcode 110010 while rf_ready=0 -> both retire with rf_we never asserted, retired +2.
- Halt: push ALU op, halt (0xFC000000), ALU op -> the third entry is refused (in_ready=0). halted=1 only after the halt dequeues; retired=2.
- Counter wrap / mid-op reset: CW=4, retire 17 entries -> retired=1. Then assert rst_n=0 with 2 entries queued -> queue empty, retired=0, no rf_we.
